// File: rtl/message_sequencer_pkg.sv
// Shared definitions for the message sequencer: FSM state encoding and
// the ASCII control characters used by capture and print.
package message_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_CAPTURE,
    ST_SET_ADDR,
    ST_WAIT_ROM,
    ST_SEND,
    ST_DONE
  } seq_state_e;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;

endpackage

// File: rtl/message_sequencer_if.sv
// Bundle of the UART rx/tx handshake and message ROM signals around the sequencer.
// The master modport is the sequencer side; slave is the surrounding top level.
interface message_sequencer_if #(
  parameter int MSG_LEN = 8,
  parameter int ADDR_W  = 4
);

  logic [7:0]           rx_data;
  logic                 new_rx_data;
  logic                 tx_busy;
  logic [7:0]           rom_data;
  logic [MSG_LEN*8-1:0] msg_bits;
  logic [ADDR_W-1:0]    rom_addr;
  logic [7:0]           tx_data;
  logic                 new_tx_data;
  logic                 printing;
  logic                 overrun;

  modport master (
    input  rx_data, new_rx_data, tx_busy, rom_data,
    output msg_bits, rom_addr, tx_data, new_tx_data, printing, overrun
  );

  modport slave (
    output rx_data, new_rx_data, tx_busy, rom_data,
    input  msg_bits, rom_addr, tx_data, new_tx_data, printing, overrun
  );

endinterface

// File: rtl/msg_capture_buffer.sv
// Packed character buffer filled from keyboard bytes, with backspace,
// terminator detection and a bulk clear back to spaces.
module msg_capture_buffer
  import message_sequencer_pkg::*;
#(
  parameter int         MSG_LEN   = 8,
  parameter logic [7:0] TERM_CHAR = CHAR_CR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_in,
  input  logic                 clear,
  output logic [MSG_LEN*8-1:0] msg_bits,
  output logic                 stored,
  output logic                 capture_end
);

  localparam int CW = $clog2(MSG_LEN + 1);

  logic [CW-1:0]          count_q, count_d;
  logic [MSG_LEN*8-1:0]   msg_q, msg_d;

  always_comb begin
    count_d     = count_q;
    msg_d       = msg_q;
    stored      = 1'b0;
    capture_end = 1'b0;
    if (clear) begin
      msg_d   = {MSG_LEN{CHAR_SPACE}};
      count_d = '0;
    end else if (byte_valid) begin
      if (byte_in == TERM_CHAR) begin
        capture_end = 1'b1;
      end else if (byte_in == CHAR_BS) begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
          for (int unsigned i = 0; i < MSG_LEN; i++) begin
            if (count_d == CW'(i)) msg_d[8*i +: 8] = CHAR_SPACE;
          end
        end
      end else begin
        stored = 1'b1;
        for (int unsigned i = 0; i < MSG_LEN; i++) begin
          if (count_q == CW'(i)) msg_d[8*i +: 8] = byte_in;
        end
        count_d     = count_q + 1'b1;
        capture_end = (count_d == CW'(MSG_LEN));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      msg_q   <= {MSG_LEN{CHAR_SPACE}};
    end else begin
      count_q <= count_d;
      msg_q   <= msg_d;
    end
  end

  assign msg_bits = msg_q;

endmodule

// File: rtl/message_sequencer.sv
// Captures a keyboard line into the ROM's character buffer, then walks the ROM
// (message, LF, CR) handing each byte to the UART transmitter.
module message_sequencer
  import message_sequencer_pkg::*;
#(
  parameter int         MSG_LEN   = 8,
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] TERM_CHAR = CHAR_CR
) (
  input  logic                 clk,
  input  logic                 rst,
  message_sequencer_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN + 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              new_tx_data_q, new_tx_data_d;
  logic              overrun_q, overrun_d;
  logic              capturing, byte_valid, clear_buf, stored, capture_end;

  assign capturing  = (state_q == ST_CAPTURE);
  assign byte_valid = bus.new_rx_data && capturing;
  assign clear_buf  = (state_q == ST_DONE);

  msg_capture_buffer #(
    .MSG_LEN   (MSG_LEN),
    .TERM_CHAR (TERM_CHAR)
  ) u_capture (
    .clk         (clk),
    .rst         (rst),
    .byte_valid  (byte_valid),
    .byte_in     (bus.rx_data),
    .clear       (clear_buf),
    .msg_bits    (bus.msg_bits),
    .stored      (stored),
    .capture_end (capture_end)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rom_addr_d    = rom_addr_q;
    tx_data_d     = tx_data_q;
    new_tx_data_d = 1'b0;
    overrun_d     = overrun_q;

    // Any byte arriving outside CAPTURE is lost; a fresh store clears the flag.
    if (stored) begin
      overrun_d = 1'b0;
    end else if (bus.new_rx_data && !capturing) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_CAPTURE: begin
        if (capture_end) begin
          idx_d   = '0;
          state_d = ST_SET_ADDR;
        end
      end
      ST_SET_ADDR: begin
        rom_addr_d = idx_q;
        state_d    = ST_WAIT_ROM;
      end
      ST_WAIT_ROM: state_d = ST_SEND;
      ST_SEND: begin
        if (!bus.tx_busy) begin
          tx_data_d     = bus.rom_data;
          new_tx_data_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SET_ADDR;
          end
        end
      end
      ST_DONE: state_d = ST_CAPTURE;
      default: state_d = ST_CAPTURE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_CAPTURE;
      idx_q         <= '0;
      rom_addr_q    <= '0;
      tx_data_q     <= '0;
      new_tx_data_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rom_addr_q    <= rom_addr_d;
      tx_data_q     <= tx_data_d;
      new_tx_data_q <= new_tx_data_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.new_tx_data = new_tx_data_q;
  assign bus.printing    = !capturing;
  assign bus.overrun     = overrun_q;

endmodule
